citron_axi_master: RTL and testbench

//  Single-outstanding AXI initiator that turns a simple valid/ready request port into AXI

---
 rtl/citron_pkg.sv | 22 ++
 rtl/citron_watchdog.sv | 30 +++
 rtl/citron_axi_master.sv | 184 ++++++++++++++++++
 tb/tb_citron_axi_master.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/citron_pkg.sv
// Shared types and constants for the Citron AXI initiator: FSM encoding,
// response status codes and the peripheral window base.
package citron_pkg;

  typedef logic [2:0] axi_mst_state_t;

  localparam axi_mst_state_t ST_IDLE  = 3'd0;
  localparam axi_mst_state_t ST_WADDR = 3'd1;
  localparam axi_mst_state_t ST_WRESP = 3'd2;
  localparam axi_mst_state_t ST_RADDR = 3'd3;
  localparam axi_mst_state_t ST_RDATA = 3'd4;
  localparam axi_mst_state_t ST_RESP  = 3'd5;
  localparam axi_mst_state_t ST_DRAIN = 3'd6;

  localparam logic [1:0] RESP_OK      = 2'b00;
  localparam logic [1:0] RESP_SLVERR  = 2'b01;
  localparam logic [1:0] RESP_NOLAST  = 2'b10;
  localparam logic [1:0] RESP_TIMEOUT = 2'b11;

  localparam logic [31:0] CITRON_BASE = 32'hF800_0000;

endpackage

// File: rtl/citron_watchdog.sv
// Saturating stall counter. expired is raised in the cycle whose clock edge
// would bring the count to TIMEOUT_CYCLES; TIMEOUT_CYCLES=0 disables it.
module citron_watchdog #(
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic clk_i,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int unsigned CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (enable && (cnt != LIMIT)) begin
      cnt <= cnt + CW'(1);
    end
  end

  assign expired = (TIMEOUT_CYCLES != 0) && enable && (cnt >= (LIMIT - CW'(1)));

endmodule

// File: rtl/citron_axi_master.sv
// Single-outstanding, single-beat AXI initiator bridging a valid/ready request
// port onto AXI, with a watchdog that turns a stalled slave into a coded error.
module citron_axi_master
  import citron_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic           clk_i,
  input  logic           rst_n,
  input  logic           req_valid_i,
  output logic           req_ready_o,
  input  logic           req_wr_i,
  input  logic [31:0]    req_addr_i,
  input  logic [31:0]    req_wdata_i,
  input  logic [3:0]     req_wstrb_i,
  output logic           resp_valid_o,
  input  logic           resp_ready_i,
  output logic [31:0]    resp_rdata_o,
  output logic [1:0]     resp_err_o,
  output logic           m_axi_awvalid,
  input  logic           m_axi_awready,
  output logic [31:0]    m_axi_awaddr,
  output logic           m_axi_wvalid,
  input  logic           m_axi_wready,
  output logic [31:0]    m_axi_wdata,
  output logic [3:0]     m_axi_wstrb,
  input  logic           m_axi_bvalid,
  output logic           m_axi_bready,
  input  logic [1:0]     m_axi_bresp,
  output logic           m_axi_arvalid,
  input  logic           m_axi_arready,
  output logic [31:0]    m_axi_araddr,
  input  logic           m_axi_rvalid,
  input  logic           m_axi_rlast,
  output logic           m_axi_rready,
  input  logic [31:0]    m_axi_rdata,
  input  logic [1:0]     m_axi_rresp,
  output axi_mst_state_t dbg_state_o
);

  // Every channel transfers exactly when valid and ready are both high at a
  // rising edge; a raised valid and its payload are held until that edge.
  axi_mst_state_t state;
  logic accept, aw_hs, w_hs, b_hs, ar_hs, r_hs, aw_done_n, w_done_n;
  logic active, expired, beat_pending;

  assign accept    = (state == ST_IDLE) && req_ready_o && req_valid_i;
  assign aw_hs     = m_axi_awvalid && m_axi_awready;
  assign w_hs      = m_axi_wvalid && m_axi_wready;
  assign b_hs      = m_axi_bvalid && m_axi_bready;
  assign ar_hs     = m_axi_arvalid && m_axi_arready;
  assign r_hs      = m_axi_rvalid && m_axi_rready;
  assign aw_done_n = !m_axi_awvalid || aw_hs;
  assign w_done_n  = !m_axi_wvalid || w_hs;
  assign active    = (state == ST_WADDR) || (state == ST_WRESP) ||
                     (state == ST_RADDR) || (state == ST_RDATA);
  // A ready still held after this edge means an abandoned beat is outstanding.
  assign beat_pending = (m_axi_bready && !m_axi_bvalid) || (m_axi_rready && !m_axi_rvalid);
  assign dbg_state_o  = state;

  citron_watchdog #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_watchdog (
    .clk_i   (clk_i),
    .rst_n   (rst_n),
    .clear   (accept),
    .enable  (active),
    .expired (expired)
  );

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state         <= ST_IDLE;
      req_ready_o   <= 1'b0;
      resp_valid_o  <= 1'b0;
      resp_rdata_o  <= '0;
      resp_err_o    <= RESP_OK;
      m_axi_awvalid <= 1'b0;
      m_axi_awaddr  <= '0;
      m_axi_wvalid  <= 1'b0;
      m_axi_wdata   <= '0;
      m_axi_wstrb   <= '0;
      m_axi_bready  <= 1'b0;
      m_axi_arvalid <= 1'b0;
      m_axi_araddr  <= '0;
      m_axi_rready  <= 1'b0;
    end else begin
      if (aw_hs) m_axi_awvalid <= 1'b0;
      if (w_hs)  m_axi_wvalid  <= 1'b0;
      if (ar_hs) m_axi_arvalid <= 1'b0;
      if (b_hs)  m_axi_bready  <= 1'b0;
      if (r_hs)  m_axi_rready  <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            req_ready_o <= 1'b0;
            if (req_wr_i) begin
              m_axi_awaddr  <= req_addr_i;
              m_axi_wdata   <= req_wdata_i;
              m_axi_wstrb   <= req_wstrb_i;
              m_axi_awvalid <= 1'b1;
              m_axi_wvalid  <= 1'b1;
              state         <= ST_WADDR;
            end else begin
              m_axi_araddr  <= req_addr_i;
              m_axi_arvalid <= 1'b1;
              state         <= ST_RADDR;
            end
          end else begin
            req_ready_o <= 1'b1;
          end
        end
        ST_WADDR: begin
          if (aw_done_n && w_done_n) begin
            m_axi_bready <= 1'b1;
            state        <= ST_WRESP;
          end else if (expired) begin
            m_axi_bready <= 1'b1;
            resp_valid_o <= 1'b1;
            resp_err_o   <= RESP_TIMEOUT;
            resp_rdata_o <= '0;
            state        <= ST_RESP;
          end
        end
        ST_WRESP: begin
          if (b_hs || expired) begin
            resp_valid_o <= 1'b1;
            resp_rdata_o <= '0;
            state        <= ST_RESP;
            if (!b_hs)                   resp_err_o <= RESP_TIMEOUT;
            else if (m_axi_bresp != 2'b00) resp_err_o <= RESP_SLVERR;
            else                         resp_err_o <= RESP_OK;
          end
        end
        ST_RADDR: begin
          if (ar_hs) begin
            m_axi_rready <= 1'b1;
            state        <= ST_RDATA;
          end else if (expired) begin
            m_axi_rready <= 1'b1;
            resp_valid_o <= 1'b1;
            resp_err_o   <= RESP_TIMEOUT;
            resp_rdata_o <= '0;
            state        <= ST_RESP;
          end
        end
        ST_RDATA: begin
          if (r_hs || expired) begin
            resp_valid_o <= 1'b1;
            state        <= ST_RESP;
            resp_rdata_o <= '0;
            if (!r_hs) begin
              resp_err_o <= RESP_TIMEOUT;
            end else if (m_axi_rresp != 2'b00) begin
              resp_err_o <= RESP_SLVERR;
            end else if (!m_axi_rlast) begin
              resp_err_o <= RESP_NOLAST;
            end else begin
              resp_err_o   <= RESP_OK;
              resp_rdata_o <= m_axi_rdata;
            end
          end
        end
        ST_RESP: begin
          if (resp_ready_i) begin
            resp_valid_o <= 1'b0;
            if (beat_pending) begin
              state <= ST_DRAIN;
            end else begin
              req_ready_o <= 1'b1;
              state       <= ST_IDLE;
            end
          end
        end
        ST_DRAIN: begin
          if (!beat_pending) begin
            req_ready_o <= 1'b1;
            state       <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_citron_axi_master.sv
// Bench for citron_axi_master: directed and random single-beat transactions
// against a cycle-level reference of the expected response, timing and drain.
module tb_citron_axi_master;
  import citron_pkg::*;

  localparam int TMO = 16;

  logic        clk_i = 1'b0;
  logic        rst_n;
  logic        req_valid_i, req_ready_o, req_wr_i;
  logic [31:0] req_addr_i, req_wdata_i;
  logic [3:0]  req_wstrb_i;
  logic        resp_valid_o, resp_ready_i;
  logic [31:0] resp_rdata_o;
  logic [1:0]  resp_err_o;
  logic        m_axi_awvalid, m_axi_awready, m_axi_wvalid, m_axi_wready;
  logic [31:0] m_axi_awaddr, m_axi_wdata, m_axi_araddr, m_axi_rdata;
  logic [3:0]  m_axi_wstrb;
  logic        m_axi_bvalid, m_axi_bready, m_axi_arvalid, m_axi_arready;
  logic [1:0]  m_axi_bresp, m_axi_rresp;
  logic        m_axi_rvalid, m_axi_rlast, m_axi_rready;
  logic [2:0]  dbg_state_o;

  int n_cmp = 0;
  int n_err = 0;
  logic [33:0] exp_q[$];

  citron_axi_master #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk_i(clk_i), .rst_n(rst_n),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_wr_i(req_wr_i),
    .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i), .req_wstrb_i(req_wstrb_i),
    .resp_valid_o(resp_valid_o), .resp_ready_i(resp_ready_i),
    .resp_rdata_o(resp_rdata_o), .resp_err_o(resp_err_o),
    .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready), .m_axi_awaddr(m_axi_awaddr),
    .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready), .m_axi_wdata(m_axi_wdata),
    .m_axi_wstrb(m_axi_wstrb),
    .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready), .m_axi_bresp(m_axi_bresp),
    .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready), .m_axi_araddr(m_axi_araddr),
    .m_axi_rvalid(m_axi_rvalid), .m_axi_rlast(m_axi_rlast), .m_axi_rready(m_axi_rready),
    .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
    .dbg_state_o(dbg_state_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] ctrl_vec();
    return {52'd0, req_ready_o, resp_valid_o, m_axi_awvalid, m_axi_wvalid, m_axi_bready,
            m_axi_arvalid, m_axi_rready, dbg_state_o, resp_err_o};
  endfunction

  function automatic logic [63:0] payload_any();
    return {63'd0, |{resp_rdata_o, m_axi_awaddr, m_axi_wdata, m_axi_wstrb, m_axi_araddr}};
  endfunction

  task automatic slave_idle();
    m_axi_awready = 1'b0; m_axi_wready = 1'b0; m_axi_bvalid = 1'b0;
    m_axi_arready = 1'b0; m_axi_rvalid = 1'b0; resp_ready_i = 1'b0;
  endtask

  // One request driven from a negedge; the slave model waits a_dly cycles of
  // AW/AR valid, w_dly cycles of W valid, then presents its beat r_dly cycles
  // after the address phase completes. Cycle 1 is the cycle after acceptance.
  task automatic run_txn(input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] wstrb, input int a_dly, input int w_dly,
                         input int r_dly, input int rr_dly, input logic [1:0] xresp,
                         input bit xlast, input logic [31:0] xdata);
    int d_cyc, e_cyc, v_cyc, rc_cyc;
    int a_wait = 0, w_wait = 0, b_wait = 0, a_cnt = 0, w_cnt = 0, bad = 0;
    int v_seen = 0, resp_done = 0, beat_cyc = 0, ready_cyc = 0;
    bit a_done = 0, w_done = 0, beat_done = 0, fin = 0, a_hs, w_hs;
    logic [1:0]  e_err;
    logic [31:0] e_rdata;
    logic [33:0] exp_cur = '0;

    d_cyc = wr ? (((a_dly > w_dly) ? a_dly : w_dly) + 1) : (a_dly + 1);
    e_cyc = d_cyc + 1 + r_dly;
    if (e_cyc > TMO) begin
      e_err = RESP_TIMEOUT; e_rdata = '0; v_cyc = TMO + 1;
    end else begin
      v_cyc = e_cyc + 1;
      if (xresp != 2'b00)    begin e_err = RESP_SLVERR; e_rdata = '0; end
      else if (!wr && !xlast) begin e_err = RESP_NOLAST; e_rdata = '0; end
      else                    begin e_err = RESP_OK; e_rdata = wr ? 32'd0 : xdata; end
    end
    rc_cyc = v_cyc + rr_dly;
    exp_q.push_back({e_err, e_rdata});

    m_axi_bresp = xresp; m_axi_rresp = xresp; m_axi_rlast = xlast; m_axi_rdata = xdata;
    req_valid_i = 1'b1; req_wr_i = wr; req_addr_i = addr;
    req_wdata_i = wdata; req_wstrb_i = wstrb;
    for (int g = 0; g < 50 && !req_ready_o; g++) @(negedge clk_i);
    check("req_accept", req_ready_o, 1);
    @(negedge clk_i);
    req_valid_i = 1'b0;

    for (int cyc = 1; cyc <= 200 && !fin; cyc++) begin
      slave_idle();
      if (beat_done && (m_axi_bready || m_axi_rready)) bad++;
      if (wr) begin
        if (m_axi_arvalid || m_axi_rready) bad++;
        if (m_axi_bready && !(a_done && w_done) && cyc <= TMO) bad++;
        a_hs = m_axi_awvalid && (a_wait >= a_dly);
        w_hs = m_axi_wvalid && (w_wait >= w_dly);
        m_axi_awready = a_hs;
        m_axi_wready  = w_hs;
        if (m_axi_awvalid) begin a_cnt++; a_wait++; end
        if (m_axi_wvalid)  begin w_cnt++; w_wait++; end
        if (a_hs) check("awaddr", m_axi_awaddr, addr);
        if (w_hs) check("wpayload", {m_axi_wstrb, m_axi_wdata}, {wstrb, wdata});
        if (a_done && w_done && !beat_done) begin
          m_axi_bvalid = (b_wait >= r_dly);
          b_wait++;
          if (m_axi_bvalid && m_axi_bready) begin beat_done = 1; beat_cyc = cyc; end
        end
        a_done |= a_hs;
        w_done |= w_hs;
      end else begin
        if (m_axi_awvalid || m_axi_wvalid || m_axi_bready) bad++;
        if (m_axi_rready && !a_done && cyc <= TMO) bad++;
        a_hs = m_axi_arvalid && (a_wait >= a_dly);
        m_axi_arready = a_hs;
        if (m_axi_arvalid) begin a_cnt++; a_wait++; end
        if (a_hs) check("araddr", m_axi_araddr, addr);
        if (a_done && !beat_done) begin
          m_axi_rvalid = (b_wait >= r_dly);
          b_wait++;
          if (m_axi_rvalid && m_axi_rready) begin beat_done = 1; beat_cyc = cyc; end
        end
        a_done |= a_hs;
      end
      if (resp_valid_o) begin
        if (resp_done != 0) begin
          bad++;
        end else begin
          if (v_seen == 0) begin
            v_seen  = cyc;
            exp_cur = (exp_q.size() != 0) ? exp_q.pop_front() : '0;
            check("resp_payload", {resp_err_o, resp_rdata_o}, exp_cur);
          end else if ({resp_err_o, resp_rdata_o} !== exp_cur) begin
            bad++;
          end
          if (cyc - v_seen >= rr_dly) begin resp_ready_i = 1'b1; resp_done = cyc; end
        end
      end
      if (req_ready_o) begin
        ready_cyc = cyc;
        fin = 1;
      end else begin
        @(negedge clk_i);
      end
    end
    slave_idle();

    check("txn_done", fin, 1);
    check("resp_cycle", v_seen, v_cyc);
    check("beat_cycle", beat_cyc, e_cyc);
    check("ready_cycle", ready_cyc, ((rc_cyc > e_cyc) ? rc_cyc : e_cyc) + 1);
    check("addr_valid_cycles", a_cnt, a_dly + 1);
    if (wr) check("wvalid_cycles", w_cnt, w_dly + 1);
    check("protocol", bad, 0);
  endtask

  initial begin
    int a_d, w_d, r_d, rr_d;
    logic [1:0] xr;

    rst_n = 1'b0;
    req_valid_i = 1'b0; req_wr_i = 1'b0; req_addr_i = '0; req_wdata_i = '0; req_wstrb_i = '0;
    m_axi_bresp = '0; m_axi_rresp = '0; m_axi_rlast = 1'b0; m_axi_rdata = '0;
    slave_idle();
    repeat (3) @(negedge clk_i);
    check("reset_ctrl", ctrl_vec(), 0);
    check("reset_payload", payload_any(), 0);
    rst_n = 1'b1;
    #1 check("ready_before_first_edge", req_ready_o, 0);
    @(negedge clk_i);
    check("ready_after_release", req_ready_o, 1);

    run_txn(1, CITRON_BASE, 32'h41, 4'h1, 0, 0, 0, 0, 2'b00, 1, 32'h0);
    run_txn(0, CITRON_BASE + 32'h4, 32'h0, 4'h0, 0, 0, 0, 0, 2'b00, 1, 32'h0000_00A5);
    run_txn(0, CITRON_BASE + 32'h3FC, 32'h0, 4'h0, 0, 0, 1, 1, 2'b11, 1, 32'hDEAD_BEEF);
    run_txn(0, CITRON_BASE + 32'h10, 32'h0, 4'h0, 1, 0, 0, 0, 2'b00, 0, 32'h1234_5678);
    run_txn(1, CITRON_BASE + 32'h20, 32'hCAFE_0001, 4'hF, 5, 0, 0, 0, 2'b00, 1, 32'h0);
    run_txn(1, CITRON_BASE + 32'h24, 32'hCAFE_0002, 4'h3, 0, 5, 1, 2, 2'b00, 1, 32'h0);
    run_txn(1, CITRON_BASE + 32'h28, 32'hCAFE_0003, 4'hC, 3, 3, 0, 0, 2'b10, 1, 32'h0);
    run_txn(1, CITRON_BASE + 32'h2C, 32'h0000_0016, 4'h1, 0, 0, 14, 0, 2'b00, 1, 32'h0);
    run_txn(1, CITRON_BASE + 32'h30, 32'h0000_0017, 4'h1, 0, 0, 15, 0, 2'b00, 1, 32'h0);
    run_txn(1, CITRON_BASE + 32'h34, 32'h0000_0030, 4'h1, 0, 0, 28, 0, 2'b00, 1, 32'h0);
    run_txn(0, CITRON_BASE + 32'h38, 32'h0, 4'h0, 0, 0, 18, 10, 2'b00, 1, 32'h5A5A_0000);
    run_txn(0, CITRON_BASE + 32'h3C, 32'h0, 4'h0, 20, 0, 0, 2, 2'b00, 1, 32'h1111_2222);
    run_txn(1, CITRON_BASE + 32'h40, 32'h4444_5555, 4'h6, 19, 1, 0, 0, 2'b00, 1, 32'h0);

    for (int i = 0; i < 24; i++) begin
      a_d  = $urandom_range(0, 3);
      w_d  = $urandom_range(0, 3);
      r_d  = ($urandom_range(0, 5) == 0) ? $urandom_range(10, 20) : $urandom_range(0, 4);
      rr_d = $urandom_range(0, 3);
      xr   = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      run_txn(1'($urandom_range(0, 1)), CITRON_BASE + 32'($urandom_range(0, 255) * 4),
              $urandom, 4'($urandom_range(1, 15)), a_d, w_d, r_d, rr_d, xr,
              ($urandom_range(0, 4) != 0), $urandom);
    end

    req_valid_i = 1'b1; req_wr_i = 1'b0; req_addr_i = CITRON_BASE + 32'h8;
    for (int g = 0; g < 50 && !req_ready_o; g++) @(negedge clk_i);
    @(negedge clk_i);
    req_valid_i = 1'b0;
    check("rst_arvalid", m_axi_arvalid, 1);
    m_axi_arready = 1'b1;
    @(negedge clk_i);
    m_axi_arready = 1'b0;
    check("rst_in_rdata", {m_axi_rready, resp_valid_o}, 2'b10);
    #2 rst_n = 1'b0;
    #1 check("rst_async_ctrl", ctrl_vec(), 0);
    check("rst_async_payload", payload_any(), 0);
    @(negedge clk_i);
    @(negedge clk_i);
    rst_n = 1'b1;
    @(negedge clk_i);
    check("ready_after_mid_reset", req_ready_o, 1);
    run_txn(0, CITRON_BASE + 32'hC, 32'h0, 4'h0, 1, 0, 2, 1, 2'b00, 1, 32'h0BAD_F00D);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
